// File: rtl/oam_dma_arbiter_if.sv
// oam_dma_arbiter_if
// Groups the buses the OAM DMA arbiter sits between:
//   cpu_*  : sm83 core side (address, write data, write strobe, read data back)
//   mem_*  : system memory decoder side (mem_d_in is combinational for mem_addr)
//   oam_*  : dedicated OAM write port
//   dma_active : CPU bus blocked indication
// Modport master is the arbiter's view; slave is the surrounding system's view.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic [7:0]  cpu_d_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_d_out;
  logic        mem_write;
  logic [7:0]  mem_d_in;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_d;
  logic        oam_write;
  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_d_out, cpu_write, mem_d_in,
    output cpu_d_in, mem_addr, mem_d_out, mem_write,
    output oam_addr, oam_d, oam_write, dma_active
  );

  modport slave (
    output cpu_addr, cpu_d_out, cpu_write, mem_d_in,
    input  cpu_d_in, mem_addr, mem_d_out, mem_write,
    input  oam_addr, oam_d, oam_write, dma_active
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
// Owns the shared memory bus between the sm83 core and the OAM DMA engine.
// Holds the DMA source register; a write to it copies DMA_LEN bytes from
// {src,8'h00} into OAM. While DMA runs, CPU accesses below OPEN_BASE are
// blocked (reads FF, writes dropped) and high-region writes are buffered.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   ce   : clock enable, one M-cycle per pulse
//   bus  : oam_dma_arbiter_if.master (cpu_*, mem_*, oam_*, dma_active)
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] OPEN_BASE    = 16'hFF00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  oam_dma_arbiter_if.master        bus
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  src_r, src_nxt_s;
  logic [7:0]  idx_r, idx_nxt_s;
  logic        blk_r, blk_nxt_s;
  logic        wb_valid_r, wb_valid_nxt_s;
  logic [15:0] wb_addr_r, wb_addr_nxt_s;
  logic [7:0]  wb_data_r, wb_data_nxt_s;

  logic        reg_hit_s;
  logic        high_s;
  logic        dma_active_s;
  logic        drain_s;
  logic        capture_s;
  logic [7:0]  src_eff_s;

  // Address decode and bus-ownership qualifiers shared by both processes.
  always_comb begin
    reg_hit_s    = (bus.cpu_addr == DMA_REG_ADDR);
    high_s       = (bus.cpu_addr >= OPEN_BASE);
    dma_active_s = (state_r == ACTIVE) || ((state_r == START) && blk_r);
    // Sources E0-FF alias onto the C0-DF work RAM echo.
    if (src_r >= 8'hE0) begin
      src_eff_s = src_r - 8'h20;
    end else begin
      src_eff_s = src_r;
    end
    // A buffered high-region write goes out in the first unblocked cycle.
    drain_s   = wb_valid_r && !dma_active_s;
    // While blocked, high-region writes are held; during a drain cycle any
    // CPU write is held too so it is not lost to the drain.
    capture_s = bus.cpu_write && !reg_hit_s && (dma_active_s ? high_s : wb_valid_r);
  end

  // Next-state logic: FF46 trigger/restart, START handoff, ACTIVE counting.
  always_comb begin
    state_nxt_s    = state_r;
    src_nxt_s      = src_r;
    idx_nxt_s      = idx_r;
    blk_nxt_s      = blk_r;
    wb_valid_nxt_s = wb_valid_r;
    wb_addr_nxt_s  = wb_addr_r;
    wb_data_nxt_s  = wb_data_r;

    if (reg_hit_s && bus.cpu_write) begin
      src_nxt_s   = bus.cpu_d_out;
      state_nxt_s = START;
      // Keep the bus blocked across START when a copy was already running.
      blk_nxt_s   = (state_r == ACTIVE) || blk_r;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        START: begin
          state_nxt_s = ACTIVE;
          idx_nxt_s   = 8'd0;
          blk_nxt_s   = 1'b0;
        end
        ACTIVE: begin
          idx_nxt_s = idx_r + 8'd1;
          if (idx_r == LAST_IDX) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = ACTIVE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end

    if (capture_s) begin
      wb_valid_nxt_s = 1'b1;
      wb_addr_nxt_s  = bus.cpu_addr;
      wb_data_nxt_s  = bus.cpu_d_out;
    end else if (drain_s) begin
      wb_valid_nxt_s = 1'b0;
    end else begin
      wb_valid_nxt_s = wb_valid_r;
    end
  end

  // State register; advances only on clock-enabled edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      src_r      <= 8'd0;
      idx_r      <= 8'd0;
      blk_r      <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_addr_r  <= 16'd0;
      wb_data_r  <= 8'd0;
    end else if (ce) begin
      state_r    <= state_nxt_s;
      src_r      <= src_nxt_s;
      idx_r      <= idx_nxt_s;
      blk_r      <= blk_nxt_s;
      wb_valid_r <= wb_valid_nxt_s;
      wb_addr_r  <= wb_addr_nxt_s;
      wb_data_r  <= wb_data_nxt_s;
    end
  end

  // Bus routing: DMA owns mem_addr in ACTIVE; otherwise CPU passes through.
  always_comb begin
    bus.cpu_d_in   = bus.mem_d_in;
    bus.mem_addr   = bus.cpu_addr;
    bus.mem_d_out  = bus.cpu_d_out;
    bus.mem_write  = 1'b0;
    bus.oam_addr   = 8'd0;
    bus.oam_d      = 8'd0;
    bus.oam_write  = 1'b0;
    bus.dma_active = dma_active_s;

    if (!rst) begin
      bus.mem_addr   = 16'd0;
      bus.mem_d_out  = 8'd0;
      bus.dma_active = 1'b0;
    end else begin
      if (state_r == ACTIVE) begin
        bus.mem_addr  = {src_eff_s, idx_r};
        bus.oam_addr  = idx_r;
        bus.oam_d     = bus.mem_d_in;
        bus.oam_write = 1'b1;
      end else begin
        bus.oam_write = 1'b0;
      end

      if (drain_s) begin
        bus.mem_addr  = wb_addr_r;
        bus.mem_d_out = wb_data_r;
        bus.mem_write = 1'b1;
      end else if (!dma_active_s) begin
        bus.mem_write = bus.cpu_write && !reg_hit_s;
      end else begin
        bus.mem_write = 1'b0;
      end

      // High-region reads during ACTIVE see whatever the memory system
      // returns; systems with a private IO/HRAM path can serve them there.
      if (reg_hit_s) begin
        bus.cpu_d_in = src_r;
      end else if (dma_active_s && !high_s) begin
        bus.cpu_d_in = 8'hFF;
      end else begin
        bus.cpu_d_in = bus.mem_d_in;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
module tb_oam_dma_arbiter;
  localparam int DMA_LEN = 160;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  oam_dma_arbiter_if bus_if();

  logic [7:0]  ram [0:65535];
  int          compares = 0;
  int          mismatches = 0;
  logic [15:0] obs_maddr[$];
  logic [7:0]  obs_oaddr[$];
  logic [7:0]  obs_d[$];
  logic [15:0] exp_maddr[$];
  logic [7:0]  exp_oaddr[$];
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];

  oam_dma_arbiter dut (.clk(clk), .rst(rst), .ce(ce), .bus(bus_if));

  assign bus_if.mem_d_in = ram[bus_if.mem_addr];

  always #5 clk = ~clk;

  // Memory model and OAM/bus-write recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && ce) begin
      if (bus_if.oam_write) begin
        obs_maddr.push_back(bus_if.mem_addr);
        obs_oaddr.push_back(bus_if.oam_addr);
        obs_d.push_back(bus_if.oam_d);
      end
      if (bus_if.mem_write) begin
        wr_addr.push_back(bus_if.mem_addr);
        wr_data.push_back(bus_if.mem_d_out);
        ram[bus_if.mem_addr] <= bus_if.mem_d_out;
      end
    end
  end

  function automatic logic [15:0] dma_addr(input logic [7:0] s, input int i);
    logic [7:0] e;
    e = (s >= 8'hE0) ? s - 8'h20 : s;
    return (16'(e) * 16'd256) + 16'(i);
  endfunction

  task automatic drive(input logic [15:0] a, input logic w, input logic [7:0] d);
    bus_if.cpu_addr  = a;
    bus_if.cpu_write = w;
    bus_if.cpu_d_out = d;
  endtask

  task automatic clear_logs();
    obs_maddr.delete(); obs_oaddr.delete(); obs_d.delete();
    exp_maddr.delete(); exp_oaddr.delete();
    wr_addr.delete(); wr_data.delete();
  endtask

  task automatic expect_copy(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      exp_maddr.push_back(dma_addr(s, i));
      exp_oaddr.push_back(8'(i));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    compares++;
    if (bus_if.mem_write !== 1'b0) begin mismatches++; $display("FAIL reset_mem_write: got %b want 0", bus_if.mem_write); end
    compares++;
    if (bus_if.oam_write !== 1'b0) begin mismatches++; $display("FAIL reset_oam_write: got %b want 0", bus_if.oam_write); end
    compares++;
    if (bus_if.dma_active !== 1'b0) begin mismatches++; $display("FAIL reset_dma_active: got %b want 0", bus_if.dma_active); end
    compares++;
    if (bus_if.mem_addr !== 16'h0000) begin mismatches++; $display("FAIL reset_mem_addr: got %h want 0000", bus_if.mem_addr); end
    compares++;
    if (bus_if.oam_addr !== 8'h00) begin mismatches++; $display("FAIL reset_oam_addr: got %h want 00", bus_if.oam_addr); end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(16'hFF46, 1'b0, 8'h00);
    @(negedge clk);
    compares++;
    if (bus_if.cpu_d_in !== 8'h00) begin mismatches++; $display("FAIL reset_src: got %h want 00", bus_if.cpu_d_in); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_transfer();
    logic exp_act;
    int   n8000;
    int   nff80;
    clear_logs();
    expect_copy(8'hC1, DMA_LEN);
    for (int c = 0; c <= 163; c++) begin
      drive(16'hC000, 1'b0, 8'h00);
      case (c)
        0:       drive(16'hFF46, 1'b1, 8'hC1);
        1:       drive(16'hA000, 1'b1, 8'h3C);
        12:      drive(16'h00C0, 1'b0, 8'h00);
        32:      drive(16'h8000, 1'b1, 8'h55);
        42:      drive(16'hFF80, 1'b1, 8'hA5);
        52:      drive(16'hFF46, 1'b0, 8'h00);
        163:     drive(16'hA000, 1'b0, 8'h00);
        default: ;
      endcase
      @(negedge clk);
      exp_act = (c >= 2) && (c <= 161);
      compares++;
      if (bus_if.dma_active !== exp_act) begin mismatches++; $display("FAIL basic_active c=%0d: got %b want %b", c, bus_if.dma_active, exp_act); end
      if (c == 0) begin
        compares++;
        if (bus_if.mem_write !== 1'b0) begin mismatches++; $display("FAIL basic_ff46_fwd: got mem_write %b want 0", bus_if.mem_write); end
      end
      if (c == 1) begin
        compares++;
        if (bus_if.mem_write !== 1'b1 || bus_if.mem_addr !== 16'hA000 || bus_if.mem_d_out !== 8'h3C) begin
          mismatches++; $display("FAIL basic_start_pass: got w=%b a=%h d=%h want 1 A000 3C", bus_if.mem_write, bus_if.mem_addr, bus_if.mem_d_out);
        end
      end
      if (c == 12) begin
        compares++;
        if (bus_if.cpu_d_in !== 8'hFF) begin mismatches++; $display("FAIL basic_block_read: got %h want FF", bus_if.cpu_d_in); end
      end
      if (c == 52) begin
        compares++;
        if (bus_if.cpu_d_in !== 8'hC1) begin mismatches++; $display("FAIL basic_src_read: got %h want C1", bus_if.cpu_d_in); end
      end
      if (c == 162) begin
        compares++;
        if (bus_if.mem_write !== 1'b1 || bus_if.mem_addr !== 16'hFF80 || bus_if.mem_d_out !== 8'hA5) begin
          mismatches++; $display("FAIL basic_drain: got w=%b a=%h d=%h want 1 FF80 A5", bus_if.mem_write, bus_if.mem_addr, bus_if.mem_d_out);
        end
      end
      if (c == 163) begin
        compares++;
        if (bus_if.cpu_d_in !== 8'h3C || bus_if.mem_write !== 1'b0) begin
          mismatches++; $display("FAIL basic_idle_read: got d=%h w=%b want 3C 0", bus_if.cpu_d_in, bus_if.mem_write);
        end
      end
      @(posedge clk); #1;
    end
    n8000 = 0; nff80 = 0;
    foreach (wr_addr[k]) begin
      if (wr_addr[k] == 16'h8000) n8000++;
      if (wr_addr[k] == 16'hFF80) nff80++;
    end
    compares++;
    if (n8000 != 0) begin mismatches++; $display("FAIL basic_drop_8000: got %0d writes want 0", n8000); end
    compares++;
    if (nff80 != 1) begin mismatches++; $display("FAIL basic_ff80_once: got %0d writes want 1", nff80); end
    compares++;
    if (obs_maddr.size() != exp_maddr.size()) begin mismatches++; $display("FAIL basic_count: got %0d want %0d", obs_maddr.size(), exp_maddr.size()); end
    for (int k = 0; k < exp_maddr.size() && k < obs_maddr.size(); k++) begin
      compares++;
      if (obs_maddr[k] !== exp_maddr[k] || obs_oaddr[k] !== exp_oaddr[k] || obs_d[k] !== ram[exp_maddr[k]]) begin
        mismatches++;
        $display("FAIL basic_beat %0d: got %h/%h/%h want %h/%h/%h", k, obs_maddr[k], obs_oaddr[k], obs_d[k], exp_maddr[k], exp_oaddr[k], ram[exp_maddr[k]]);
      end
    end
  endtask

  task automatic test_random_src();
    logic [7:0] s;
    logic       exp_act;
    for (int t = 0; t < 3; t++) begin
      s = (t == 0) ? 8'hFE : 8'($urandom_range(0, 255));
      clear_logs();
      expect_copy(s, DMA_LEN);
      for (int c = 0; c <= 163; c++) begin
        drive(16'hC000, 1'b0, 8'h00);
        if (c == 0) drive(16'hFF46, 1'b1, s);
        if (c == 163) drive(16'hFF46, 1'b0, 8'h00);
        @(negedge clk);
        exp_act = (c >= 2) && (c <= 161);
        compares++;
        if (bus_if.dma_active !== exp_act) begin mismatches++; $display("FAIL rand_active s=%h c=%0d: got %b want %b", s, c, bus_if.dma_active, exp_act); end
        if (c == 163) begin
          compares++;
          if (bus_if.cpu_d_in !== s) begin mismatches++; $display("FAIL rand_src_read: got %h want %h", bus_if.cpu_d_in, s); end
        end
        @(posedge clk); #1;
      end
      compares++;
      if (obs_maddr.size() != exp_maddr.size()) begin mismatches++; $display("FAIL rand_count s=%h: got %0d want %0d", s, obs_maddr.size(), exp_maddr.size()); end
      for (int k = 0; k < exp_maddr.size() && k < obs_maddr.size(); k++) begin
        compares++;
        if (obs_maddr[k] !== exp_maddr[k] || obs_oaddr[k] !== exp_oaddr[k] || obs_d[k] !== ram[exp_maddr[k]]) begin
          mismatches++;
          $display("FAIL rand_beat s=%h %0d: got %h/%h/%h want %h/%h/%h", s, k, obs_maddr[k], obs_oaddr[k], obs_d[k], exp_maddr[k], exp_oaddr[k], ram[exp_maddr[k]]);
        end
      end
    end
  endtask

  task automatic test_restart();
    logic [7:0] s1;
    logic       exp_act;
    s1 = 8'($urandom_range(0, 255));
    clear_logs();
    expect_copy(s1, 50);
    expect_copy(8'hD0, DMA_LEN);
    for (int c = 0; c <= 214; c++) begin
      drive(16'hC000, 1'b0, 8'h00);
      if (c == 0) drive(16'hFF46, 1'b1, s1);
      if (c == 51) drive(16'hFF46, 1'b1, 8'hD0);
      if (c == 52) drive(16'hFF80, 1'b0, 8'h00);
      if (c == 214) drive(16'hFF46, 1'b0, 8'h00);
      @(negedge clk);
      exp_act = (c >= 2) && (c <= 212);
      compares++;
      if (bus_if.dma_active !== exp_act) begin mismatches++; $display("FAIL restart_active c=%0d: got %b want %b", c, bus_if.dma_active, exp_act); end
      if (c == 52) begin
        compares++;
        if (bus_if.oam_write !== 1'b0 || bus_if.mem_addr !== 16'hFF80 || bus_if.cpu_d_in !== ram[16'hFF80]) begin
          mismatches++;
          $display("FAIL restart_start_hram: got ow=%b a=%h d=%h want 0 FF80 %h", bus_if.oam_write, bus_if.mem_addr, bus_if.cpu_d_in, ram[16'hFF80]);
        end
      end
      if (c == 214) begin
        compares++;
        if (bus_if.cpu_d_in !== 8'hD0) begin mismatches++; $display("FAIL restart_src_read: got %h want D0", bus_if.cpu_d_in); end
      end
      @(posedge clk); #1;
    end
    compares++;
    if (obs_maddr.size() != exp_maddr.size()) begin mismatches++; $display("FAIL restart_count: got %0d want %0d", obs_maddr.size(), exp_maddr.size()); end
    for (int k = 0; k < exp_maddr.size() && k < obs_maddr.size(); k++) begin
      compares++;
      if (obs_maddr[k] !== exp_maddr[k] || obs_oaddr[k] !== exp_oaddr[k] || obs_d[k] !== ram[exp_maddr[k]]) begin
        mismatches++;
        $display("FAIL restart_beat %0d: got %h/%h/%h want %h/%h/%h", k, obs_maddr[k], obs_oaddr[k], obs_d[k], exp_maddr[k], exp_oaddr[k], ram[exp_maddr[k]]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    s = 8'($urandom_range(0, 255));
    clear_logs();
    expect_copy(s, 80);
    for (int c = 0; c <= 81; c++) begin
      drive(16'hC000, 1'b0, 8'h00);
      if (c == 0) drive(16'hFF46, 1'b1, s);
      @(negedge clk);
      @(posedge clk); #1;
    end
    compares++;
    if (bus_if.oam_write !== 1'b1 || bus_if.oam_addr !== 8'd80) begin
      mismatches++; $display("FAIL rstmid_pre: got ow=%b idx=%h want 1 50", bus_if.oam_write, bus_if.oam_addr);
    end
    rst = 1'b0;
    #1;
    compares++;
    if (bus_if.oam_write !== 1'b0 || bus_if.dma_active !== 1'b0) begin
      mismatches++; $display("FAIL rstmid_abort: got ow=%b act=%b want 0 0", bus_if.oam_write, bus_if.dma_active);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(16'hFF46, 1'b0, 8'h00);
    @(negedge clk);
    compares++;
    if (bus_if.cpu_d_in !== 8'h00 || bus_if.dma_active !== 1'b0) begin
      mismatches++; $display("FAIL rstmid_src: got d=%h act=%b want 00 0", bus_if.cpu_d_in, bus_if.dma_active);
    end
    @(posedge clk); #1;
    drive(16'hC000, 1'b0, 8'h00);
    repeat (4) begin @(posedge clk); end
    #1;
    compares++;
    if (obs_maddr.size() != exp_maddr.size()) begin mismatches++; $display("FAIL rstmid_count: got %0d want %0d", obs_maddr.size(), exp_maddr.size()); end
    for (int k = 0; k < exp_maddr.size() && k < obs_maddr.size(); k++) begin
      compares++;
      if (obs_maddr[k] !== exp_maddr[k] || obs_oaddr[k] !== exp_oaddr[k] || obs_d[k] !== ram[exp_maddr[k]]) begin
        mismatches++;
        $display("FAIL rstmid_beat %0d: got %h/%h/%h want %h/%h/%h", k, obs_maddr[k], obs_oaddr[k], obs_d[k], exp_maddr[k], exp_oaddr[k], ram[exp_maddr[k]]);
      end
    end
  endtask

  task automatic test_ce_sparse();
    logic [7:0] s;
    int         wr_clocks;
    int         act_clocks;
    s = 8'($urandom_range(0, 255));
    clear_logs();
    expect_copy(s, DMA_LEN);
    wr_clocks = 0; act_clocks = 0;
    for (int n = 0; n < 4 * 164; n++) begin
      ce = (n % 4 == 0);
      if (n < 4) drive(16'hFF46, 1'b1, s);
      else drive(16'hC000, 1'b0, 8'h00);
      @(negedge clk);
      if (bus_if.oam_write === 1'b1) wr_clocks++;
      if (bus_if.dma_active === 1'b1) act_clocks++;
      @(posedge clk); #1;
    end
    ce = 1'b1;
    compares++;
    if (wr_clocks != 640) begin mismatches++; $display("FAIL ce_oam_clocks: got %0d want 640", wr_clocks); end
    compares++;
    if (act_clocks != 640) begin mismatches++; $display("FAIL ce_active_clocks: got %0d want 640", act_clocks); end
    compares++;
    if (obs_maddr.size() != exp_maddr.size()) begin mismatches++; $display("FAIL ce_count: got %0d want %0d", obs_maddr.size(), exp_maddr.size()); end
    for (int k = 0; k < exp_maddr.size() && k < obs_maddr.size(); k++) begin
      compares++;
      if (obs_maddr[k] !== exp_maddr[k] || obs_oaddr[k] !== exp_oaddr[k] || obs_d[k] !== ram[exp_maddr[k]]) begin
        mismatches++;
        $display("FAIL ce_beat %0d: got %h/%h/%h want %h/%h/%h", k, obs_maddr[k], obs_oaddr[k], obs_d[k], exp_maddr[k], exp_oaddr[k], ram[exp_maddr[k]]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    ce  = 1'b1;
    drive(16'h1234, 1'b1, 8'h77);
    for (int a = 0; a < 65536; a++) ram[a] <= 8'($urandom);
    test_reset();
    test_basic_transfer();
    test_random_src();
    test_restart();
    test_reset_mid();
    test_ce_sparse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the shared memory bus between the sm83 core and the OAM DMA engine.
- Implements the DMA source register at FF46. A write to it triggers a 160-byte copy from {src,8'h00} into OAM.
- While DMA is active, CPU accesses below FF00 are blocked: reads return FF, writes are dropped.
- Sits between the core's addr/d_in/d_out/write pins and the system memory decoder. Has a dedicated OAM write port.

Parameters:
DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source register.
DMA_LEN, 160, bytes per transfer (legal range 1..256).
OPEN_BASE, 16'hFF00, lowest CPU address still reachable during DMA (IO + HRAM).

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
ce  input  1  clock enable; one M-cycle per ce pulse. All state advances only on posedge clk with ce=1.
cpu_addr  input  16  core address.
cpu_d_out  input  8  core write data.
cpu_write  input  1  core write strobe.
cpu_d_in  output  8  read data returned to core.
mem_addr  output  16  system bus address.
mem_d_out  output  8  system bus write data.
mem_write  output  1  system bus write strobe.
mem_d_in  input  8  system bus read data; combinational, valid in the same cycle as mem_addr.
oam_addr  output  8  OAM byte index 0..DMA_LEN-1.
oam_d  output  8  OAM write data.
oam_write  output  1  OAM write strobe, qualified by ce downstream.
dma_active  output  1  high while the CPU bus is blocked.

Behaviour:
- Registered state:
  - state in {IDLE, START, ACTIVE}.
  - src[7:0], the last value written to FF46.
  - idx[7:0], the transfer counter.
  - blk, the "block during START" flag.
- Reset (rst=0, asynchronous):
  - state=IDLE, src=0, idx=0, blk=0.
  - Outputs forced to: mem_write=0, oam_write=0, dma_active=0, mem_addr=0, oam_addr=0.
  - Reset mid-transfer aborts the transfer immediately. No further oam_write is issued.
- FF46 access (any state):
  - CPU read returns src.
  - CPU write with ce=1 loads src <= cpu_d_out and sets state <= START; blk <= (state==ACTIVE || blk).
  - FF46 is never forwarded: mem_write=0 for that address.
- START: the next ce cycle moves to ACTIVE, idx <= 0, blk <= 0.
- ACTIVE, per ce cycle with index i:
  - mem_addr = {src_eff, i}, where src_eff = (src >= 8'hE0) ? src - 8'h20 : src.
  - mem_write=0; oam_addr=i; oam_d=mem_d_in; oam_write=1.
  - At the ce edge: idx <= i+1. If i == DMA_LEN-1, state <= IDLE.
  - Exactly DMA_LEN oam_write cycles per uninterrupted transfer.
- Restart: an FF46 write during ACTIVE abandons the current index and returns to START with the new src. The bus stays blocked through START (blk=1). The new copy restarts at idx 0.
- dma_active = (state==ACTIVE) || (state==START && blk).
- CPU routing:
  - When dma_active=0, CPU addresses other than FF46 pass straight through: mem_addr=cpu_addr, mem_d_out=cpu_d_out, mem_write=cpu_write, cpu_d_in=mem_d_in.
  - When dma_active=1 and cpu_addr >= OPEN_BASE (excluding FF46), cpu_d_in=mem_d_in; a CPU write is carried out-of-band on mem_write only if the memory system permits.
  - Simplest compliant choice: the DMA owns mem_addr, CPU writes to FF00-FFFF are held in a 1-entry buffer and issued in the first non-ACTIVE cycle. Buffer depth 1; a second write to a different address while the buffer is full overwrites it.
  - When dma_active=1 and cpu_addr < OPEN_BASE: cpu_d_in=8'hFF and CPU writes are dropped.
- The first START cycle after a fresh trigger from IDLE does not block. The CPU bus is unaffected for exactly one M-cycle.
- ce=0: no state change; combinational outputs still reflect current state. oam_write is gated by the consumer with ce.

Test Plan:
- Reset, then a CPU write FF46=8'hC1 -> 1 unblocked cycle, then 160 cycles with oam_write=1, mem_addr C100..C19F, oam_addr 00..9F, oam_d equal to the model RAM bytes. Then IDLE and dma_active=0.
- During ACTIVE, CPU reads 8'h00C0 -> cpu_d_in=FF. CPU reads FF80 -> HRAM value. CPU writes 8'h8000 -> no mem_write to 8000 ever.
- Write FF46=8'hFE -> source bytes read from DE00..DE9F. Reading FF46 returns 8'hFE.
- At idx=50, write FF46=8'hD0 -> dma_active stays 1 through START. Copy restarts at D000/oam_addr 0. Total of 50+160 oam_write pulses.
- Assert rst low at idx=80 -> oam_write=0 and dma_active=0 immediately. After release, the src readback is 8'h00.
- ce toggles 1-of-4 -> the transfer takes 640 clocks with identical addresses and data.
